enemy_wave_controller: RTL
==========================

# enemy_wave_controller

Sequences the enemy instances for one level: holds them in reset, releases them one by one on a fixed spawn gap, and tracks which are alive. It also merges their per-enemy kill and death flags into level-clear and player-dead results. It sits in the top module between the game-start logic and the array of enemy instances, driving their `enemy_start` pulses, spawn coordinates and reset.

## Interface
- `NUM_ENEMIES`, 4: number of enemy slots; 1..8.
- `SPAWN_GAP`, 25_000_000: clock cycles between consecutive `enemy_start` pulses; ≥2.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high.
- `game_start`  in  1: one-cycle pulse from the top module requesting a new wave.
- `enemy_killed`  in  NUM_ENEMIES: per-slot level, 1 = enemy destroyed by an explosion.
- `enemy_death`  in  NUM_ENEMIES: per-slot level, 1 = that enemy touched the player.
- `enemy_rst`  out  1: registered; drives the enemy instances' reset.
- `enemy_start`  out  NUM_ENEMIES: registered one-cycle start pulse per slot.
- `set_x_bus`, `set_y_bus`  out  10·NUM_ENEMIES: spawn coordinates; slot i is bits [10i+9:10i]; constant.
- `alive_count`  out  4: number of started slots not killed.
- `player_dead`  out  1: sticky; cleared only by `reset` or an accepted `game_start`.
- `level_clear`  out  1: sticky; cleared under the same conditions as `player_dead`.
- `wave_state`  out  3: current FSM state encoding, for debug.

## Operation
- **States:**
  - IDLE=0, RST=1, SPAWN=2, GAP=3, ACTIVE=4, CLEAR=5, OVER=6.
  - Values on `reset`: IDLE, `enemy_rst`=1, `enemy_start`=0, `started`=0, `slot`=0, `gap_cnt`=0, `player_dead`=0, `level_clear`=0.
- **IDLE:**
  - `enemy_rst` is held at 1.
  - On `game_start` → RST.
- **RST:**
  - `enemy_rst` is 1 for exactly this one cycle.
  - Clears `started`, `slot`, `player_dead` and `level_clear`.
  - → SPAWN.
- **SPAWN:**
  - `enemy_rst`=0.
  - Pulses `enemy_start[slot]` and sets `started[slot]`.
  - If `slot` is the last slot → ACTIVE.
  - Otherwise loads `gap_cnt`=SPAWN_GAP−2 and → GAP.
- **GAP:**
  - Decrements `gap_cnt`.
  - At 0, increments `slot` and → SPAWN.
  - Consecutive `enemy_start` pulses are therefore exactly SPAWN_GAP cycles apart.
- **Live mask** = `started & ~enemy_killed`.
- **Death check** (in SPAWN, GAP and ACTIVE):
  - If `|(enemy_death & live_mask)`: → OVER and set `player_dead`.
  - Pending spawns are abandoned.
  - Death takes priority over clear in the same cycle.
  - A death flag from an unstarted or killed slot is ignored.
- **Clear check** (ACTIVE only): if `live_mask`==0 → CLEAR and set `level_clear`.
- **CLEAR / OVER:**
  - The enemies keep running; `enemy_rst` stays 0.
  - On `game_start` → RST, which starts a new wave.
- `game_start` is ignored in RST, SPAWN, GAP and ACTIVE.
- **`alive_count`** = popcount(`live_mask`), combinational from registered `started`.
- **Spawn table** (package constants; slots beyond 4 repeat modulo 4): (768,34), (143,500), (768,500), (455,258). All lie inside the 143..768 × 34..500 wall box.

## Timing
- Latencies:
  - `game_start` sampled at edge N → `enemy_rst`=1 during cycle N+1.
  - First `enemy_start` pulse during cycle N+2.
- Slot k start pulse occurs at cycle N+2+k·SPAWN_GAP.
- `player_dead` and `level_clear` rise one cycle after the qualifying input is sampled.
- `enemy_start` is never high in the same cycle as `enemy_rst`.
- At most one `enemy_start` bit is high in any cycle.
- `reset` asserted mid-wave:
  - All outputs return to their reset values immediately (asynchronously).
  - `enemy_rst` goes to 1 immediately.
- `gap_cnt` width is $clog2(SPAWN_GAP); it cannot wrap because it is reloaded before each use.

## Structure
- Shared package `bomberman_pkg`:
  - Screen bounds: MIN_X=143, MAX_X=784, MIN_Y=34, MAX_Y=516.
  - Sprite size: 16.
  - Spawn tables SPAWN_X[4] and SPAWN_Y[4].
  - Wave state encodings.
- Sub-module `popcount8`: combinational popcount of up to 8 bits, used for `alive_count`.
- All remaining logic (FSM, `gap_cnt`, `started`, sticky flags) lives in a single always block in the top-level file.

## Test plan
All scenarios use SPAWN_GAP=4 and NUM_ENEMIES=4.
1. **Reset and start:**
   - Stimulus: `reset`, then `game_start` at cycle 10.
   - Required: `enemy_rst`=1 at cycle 11; `enemy_start`=0001, 0010, 0100, 1000 at cycles 12, 16, 20, 24; `alive_count` steps 1→4; `wave_state`=4 at cycle 25.
2. **Level clear:**
   - Stimulus: after full spawn, raise `enemy_killed` bits one at a time.
   - Required: `alive_count` 4→0; `level_clear`=1 the cycle after the last bit; `player_dead`=0.
3. **Death during spawn:**
   - Stimulus: `enemy_death[0]`=1 at cycle 18.
   - Required: `player_dead`=1 at cycle 19; state OVER; no further `enemy_start` pulses.
4. **Masked death:**
   - Stimulus: `enemy_death[3]`=1 before slot 3 starts; later `enemy_death[1]`=1 with `enemy_killed[1]`=1.
   - Required: `player_dead` stays 0 in both cases.
5. **Simultaneous events:**
   - Stimulus: the last live enemy's `enemy_killed` and another live slot's `enemy_death` rise in the same cycle.
   - Required: OVER, `player_dead`=1, `level_clear`=0.
6. **Restart and asynchronous reset:**
   - Stimulus: `game_start` in OVER; later assert `reset` mid-GAP.
   - Required: on the restart, flags clear and the spawn sequence repeats from slot 0; on `reset`, outputs take reset values immediately and the state is IDLE.

Source files
------------

// File: rtl/bomberman_pkg.sv
// -----------------------------------------------------------------------------
// bomberman_pkg
// Shared constants for the bomberman level logic: screen bounds, sprite size,
// the enemy spawn table and the enemy wave controller state encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package bomberman_pkg;

    // Playfield bounds in pixel coordinates.
    localparam int MIN_X       = 143;
    localparam int MAX_X       = 784;
    localparam int MIN_Y       = 34;
    localparam int MAX_Y       = 516;
    localparam int SPRITE_SIZE = 16;

    // Enemy spawn points. Element [i] belongs to slot i; slots beyond the
    // table length reuse the table modulo its length. Every point sits
    // inside the 143..768 x 34..500 wall box.
    localparam int SPAWN_TABLE_LEN = 4;
    localparam logic [SPAWN_TABLE_LEN-1:0][9:0] SPAWN_X = {10'd455, 10'd768, 10'd143, 10'd768};
    localparam logic [SPAWN_TABLE_LEN-1:0][9:0] SPAWN_Y = {10'd258, 10'd500, 10'd500, 10'd34};

    // Wave controller states; the encoding is visible on the debug port.
    typedef enum logic [2:0] {
        WAVE_IDLE   = 3'd0,
        WAVE_RST    = 3'd1,
        WAVE_SPAWN  = 3'd2,
        WAVE_GAP    = 3'd3,
        WAVE_ACTIVE = 3'd4,
        WAVE_CLEAR  = 3'd5,
        WAVE_OVER   = 3'd6
    } wave_state_t;

endpackage

// File: rtl/popcount8.sv
// -----------------------------------------------------------------------------
// popcount8
// Combinational population count of an 8-bit vector.
// Ports:
//   i_bits  in  8 : vector to count (unused upper bits tied low by the caller)
//   o_count out 4 : number of ones in i_bits (0..8)
// -----------------------------------------------------------------------------
module popcount8 (
    input  logic [7:0] i_bits,
    output logic [3:0] o_count
);

    always_comb begin
        // NOTE: assigning a default before the loop keeps this purely
        // combinational; a path that leaves the output unassigned infers a latch.
        o_count = 4'd0;
        for (int i = 0; i < 8; i++) begin
            o_count = o_count + {3'b000, i_bits[i]};
        end
    end

endmodule

// File: rtl/enemy_wave_controller.sv
// -----------------------------------------------------------------------------
// enemy_wave_controller
// Sequences the enemies of one level: holds them in reset, releases them one
// per SPAWN_GAP cycles, tracks which are alive and merges their kill/death
// flags into sticky level_clear / player_dead results.
// Ports:
//   clk          in  1             : system clock
//   reset        in  1             : asynchronous, active-high reset
//   game_start   in  1             : one-cycle request for a new wave
//   enemy_killed in  NUM_ENEMIES   : per-slot level, enemy destroyed
//   enemy_death  in  NUM_ENEMIES   : per-slot level, enemy touched the player
//   enemy_rst    out 1             : registered reset for the enemy instances
//   enemy_start  out NUM_ENEMIES   : registered one-cycle start pulse per slot
//   set_x_bus    out 10*NUM_ENEMIES: spawn X per slot, slot i at [10i+9:10i]
//   set_y_bus    out 10*NUM_ENEMIES: spawn Y per slot, slot i at [10i+9:10i]
//   alive_count  out 4             : started slots not killed
//   player_dead  out 1             : sticky, a live enemy touched the player
//   level_clear  out 1             : sticky, every started enemy killed
//   wave_state   out 3             : current state encoding (debug)
// -----------------------------------------------------------------------------
module enemy_wave_controller
    import bomberman_pkg::*;
#(
    parameter int NUM_ENEMIES = 4,
    parameter int SPAWN_GAP   = 25_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      game_start,
    input  logic [NUM_ENEMIES-1:0]    enemy_killed,
    input  logic [NUM_ENEMIES-1:0]    enemy_death,
    output logic                      enemy_rst,
    output logic [NUM_ENEMIES-1:0]    enemy_start,
    output logic [10*NUM_ENEMIES-1:0] set_x_bus,
    output logic [10*NUM_ENEMIES-1:0] set_y_bus,
    output logic [3:0]                alive_count,
    output logic                      player_dead,
    output logic                      level_clear,
    output logic [2:0]                wave_state
);

    localparam int SLOT_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
    localparam int GAP_W  = $clog2(SPAWN_GAP);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_ENEMIES - 1);
    // SPAWN and the final GAP cycle account for two of the SPAWN_GAP cycles.
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(SPAWN_GAP - 2);

    // Registered state
    wave_state_t             r_state;
    logic [SLOT_W-1:0]       r_slot;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [NUM_ENEMIES-1:0]  r_started;
    logic                    r_enemy_rst;
    logic [NUM_ENEMIES-1:0]  r_enemy_start;
    logic                    r_player_dead;
    logic                    r_level_clear;

    // Next-state values
    wave_state_t             w_next_state;
    logic [SLOT_W-1:0]       w_next_slot;
    logic [GAP_W-1:0]        w_next_gap_cnt;
    logic [NUM_ENEMIES-1:0]  w_next_started;
    logic                    w_next_enemy_rst;
    logic [NUM_ENEMIES-1:0]  w_next_enemy_start;
    logic                    w_next_player_dead;
    logic                    w_next_level_clear;

    logic [NUM_ENEMIES-1:0]  w_live_mask;
    logic                    w_death;
    logic [7:0]              w_live8;

    assign w_live_mask = r_started & ~enemy_killed;
    // Death flags of unstarted or already-killed slots are stale and ignored.
    assign w_death     = |(enemy_death & w_live_mask);

    always_comb begin
        w_next_state       = r_state;
        w_next_slot        = r_slot;
        w_next_gap_cnt     = r_gap_cnt;
        w_next_started     = r_started;
        w_next_player_dead = r_player_dead;
        w_next_level_clear = r_level_clear;

        unique case (r_state)
            WAVE_IDLE, WAVE_CLEAR, WAVE_OVER: begin
                // Accepting a new wave clears the previous results at once,
                // so they already read 0 while the enemies are held in reset.
                if (game_start) begin
                    w_next_state       = WAVE_RST;
                    w_next_started     = '0;
                    w_next_slot        = '0;
                    w_next_gap_cnt     = '0;
                    w_next_player_dead = 1'b0;
                    w_next_level_clear = 1'b0;
                end
            end
            WAVE_RST: begin
                w_next_state       = WAVE_SPAWN;
                w_next_started     = '0;
                w_next_slot        = '0;
                w_next_player_dead = 1'b0;
                w_next_level_clear = 1'b0;
            end
            WAVE_SPAWN: begin
                // The slot being pulsed counts as started even if the wave
                // ends this cycle: that enemy has been released.
                w_next_started[r_slot] = 1'b1;
                if (w_death) begin
                    w_next_state       = WAVE_OVER;
                    w_next_player_dead = 1'b1;
                end else if (r_slot == LAST_SLOT) begin
                    w_next_state = WAVE_ACTIVE;
                end else begin
                    w_next_gap_cnt = GAP_LOAD;
                    w_next_state   = WAVE_GAP;
                end
            end
            WAVE_GAP: begin
                if (w_death) begin
                    w_next_state       = WAVE_OVER;
                    w_next_player_dead = 1'b1;
                end else if (r_gap_cnt == '0) begin
                    w_next_slot  = r_slot + 1'b1;
                    w_next_state = WAVE_SPAWN;
                end else begin
                    w_next_gap_cnt = r_gap_cnt - 1'b1;
                end
            end
            WAVE_ACTIVE: begin
                // Death wins over clear when both happen in one cycle.
                if (w_death) begin
                    w_next_state       = WAVE_OVER;
                    w_next_player_dead = 1'b1;
                end else if (w_live_mask == '0) begin
                    w_next_state       = WAVE_CLEAR;
                    w_next_level_clear = 1'b1;
                end
            end
            default: begin
                w_next_state = WAVE_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with
        // the state they belong to; a pulse and enemy_rst never overlap.
        w_next_enemy_rst   = (w_next_state == WAVE_IDLE) || (w_next_state == WAVE_RST);
        w_next_enemy_start = '0;
        if (w_next_state == WAVE_SPAWN) begin
            w_next_enemy_start[w_next_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= WAVE_IDLE;
            r_slot        <= '0;
            r_gap_cnt     <= '0;
            r_started     <= '0;
            r_enemy_rst   <= 1'b1;
            r_enemy_start <= '0;
            r_player_dead <= 1'b0;
            r_level_clear <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            r_state       <= w_next_state;
            r_slot        <= w_next_slot;
            r_gap_cnt     <= w_next_gap_cnt;
            r_started     <= w_next_started;
            r_enemy_rst   <= w_next_enemy_rst;
            r_enemy_start <= w_next_enemy_start;
            r_player_dead <= w_next_player_dead;
            r_level_clear <= w_next_level_clear;
        end
    end

    // Zero-extend the live mask to the popcount width.
    always_comb begin
        w_live8                  = 8'd0;
        w_live8[NUM_ENEMIES-1:0] = w_live_mask;
    end

    popcount8 u_popcount8 (
        .i_bits  (w_live8),
        .o_count (alive_count)
    );

    for (genvar i = 0; i < NUM_ENEMIES; i++) begin : g_spawn
        assign set_x_bus[10*i +: 10] = SPAWN_X[i % SPAWN_TABLE_LEN];
        assign set_y_bus[10*i +: 10] = SPAWN_Y[i % SPAWN_TABLE_LEN];
    end

    assign enemy_rst   = r_enemy_rst;
    assign enemy_start = r_enemy_start;
    assign player_dead = r_player_dead;
    assign level_clear = r_level_clear;
    assign wave_state  = r_state;

endmodule
